// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts one RV32I R-type/I-type ALU instruction, drives the
// decoded operation to an external ALU for exactly one cycle, and returns the
// result through a valid/ready response handshake.
//
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   in_valid/in_ready            instruction handshake (ready only in IDLE)
//   instr, rs1_val, rs2_val      instruction word and source operands
//   alu_a, alu_b, alu_control    operands/opcode to the external ALU (EXEC only)
//   alu_result/zero/overflow     values returned by the external ALU
//   out_valid/out_ready          response handshake
//   out_result/zero/overflow/illegal  response payload
//
// Configuration macro: ALU_SEQ_OVERFLOW_TRAP_EN
//   When defined, an overflowing ADD/SUB is reported as illegal with a zero
//   result and out_overflow=1. When undefined, the wrapped result is returned.
module alu_sequencer #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  instr,
  input  logic [N-1:0] rs1_val,
  input  logic [N-1:0] rs2_val,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_control,
  input  logic [N-1:0] alu_result,
  input  logic         alu_overflow,
  input  logic         alu_zero,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_result,
  output logic         out_zero,
  output logic         out_overflow,
  output logic         out_illegal
);

  localparam int unsigned CTRL_W = 4;

  typedef enum logic [CTRL_W-1:0] {
    ALU_NOP  = 4'b0000,
    ALU_AND  = 4'b0001,
    ALU_OR   = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_ADD  = 4'b1000,
    ALU_SUB  = 4'b1100,
    ALU_SLT  = 4'b1101,
    ALU_SLTU = 4'b1111
  } alu_control_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Register fields the sequencer never looks at.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[19:15], instr[11:7]};

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Instruction decode: legality, ALU code and operand b.
  logic         dec_legal;
  alu_control_t dec_ctrl;
  logic [N-1:0] dec_b;
  always_comb begin
    dec_legal = 1'b0;
    dec_ctrl  = ALU_NOP;
    dec_b     = '0;
    unique case (funct3)
      3'b000:  dec_ctrl = ALU_ADD;
      3'b001:  dec_ctrl = ALU_SLL;
      3'b010:  dec_ctrl = ALU_SLT;
      3'b011:  dec_ctrl = ALU_SLTU;
      3'b100:  dec_ctrl = ALU_XOR;
      3'b101:  dec_ctrl = ALU_SRL;
      3'b110:  dec_ctrl = ALU_OR;
      default: dec_ctrl = ALU_AND;
    endcase
    if (opcode == OPC_R) begin
      dec_b = rs2_val;
      if (funct7 == F7_BASE) begin
        dec_legal = 1'b1;
      end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
        dec_legal = 1'b1;
        dec_ctrl  = (funct3 == 3'b000) ? ALU_SUB : ALU_SRA;
      end
    end else if (opcode == OPC_I) begin
      if (funct3 == 3'b001 || funct3 == 3'b101) begin
        // Shift-immediates: shamt zero-extended, upper bits select SRAI.
        dec_b = N'(instr[24:20]);
        if (funct7 == F7_BASE) begin
          dec_legal = 1'b1;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          dec_legal = 1'b1;
          dec_ctrl  = ALU_SRA;
        end
      end else begin
        dec_legal = 1'b1;
        dec_b     = {{(N-12){instr[31]}}, instr[31:20]};
      end
    end
  end

  state_t       state_q, state_d;
  logic         in_ready_q, in_ready_d;
  logic [N-1:0] alu_a_q, alu_a_d;
  logic [N-1:0] alu_b_q, alu_b_d;
  logic [3:0]   alu_ctrl_q, alu_ctrl_d;
  logic         addsub_q, addsub_d;
  logic         out_valid_q, out_valid_d;
  logic [N-1:0] out_result_q, out_result_d;
  logic         out_zero_q, out_zero_d;
  logic         out_ovf_q, out_ovf_d;
  logic         out_ill_q, out_ill_d;

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    in_ready_d   = in_ready_q;
    alu_a_d      = '0;
    alu_b_d      = '0;
    alu_ctrl_d   = ALU_NOP;
    addsub_d     = addsub_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_zero_d   = out_zero_q;
    out_ovf_d    = out_ovf_q;
    out_ill_d    = out_ill_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          in_ready_d = 1'b0;
          if (dec_legal) begin
            state_d    = EXEC;
            alu_a_d    = rs1_val;
            alu_b_d    = dec_b;
            alu_ctrl_d = dec_ctrl;
            addsub_d   = (dec_ctrl == ALU_ADD) || (dec_ctrl == ALU_SUB);
          end else begin
            // Illegal: respond directly, the ALU is never driven.
            state_d      = RESP;
            out_valid_d  = 1'b1;
            out_result_d = '0;
            out_zero_d   = 1'b1;
            out_ovf_d    = 1'b0;
            out_ill_d    = 1'b1;
          end
        end
      end
      EXEC: begin
        state_d      = RESP;
        out_valid_d  = 1'b1;
        out_result_d = alu_result;
        out_zero_d   = alu_zero;
        out_ovf_d    = addsub_q & alu_overflow;
        out_ill_d    = 1'b0;
`ifdef ALU_SEQ_OVERFLOW_TRAP_EN
        if (addsub_q && alu_overflow) begin
          out_result_d = '0;
          out_zero_d   = 1'b1;
          out_ill_d    = 1'b1;
        end
`endif
      end
      RESP: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b1;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctrl_q   <= ALU_NOP;
      addsub_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_zero_q   <= 1'b0;
      out_ovf_q    <= 1'b0;
      out_ill_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_ctrl_q   <= alu_ctrl_d;
      addsub_q     <= addsub_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_zero_q   <= out_zero_d;
      out_ovf_q    <= out_ovf_d;
      out_ill_q    <= out_ill_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_control  = alu_ctrl_q;
  assign out_valid    = out_valid_q;
  assign out_result   = out_result_q;
  assign out_zero     = out_zero_q;
  assign out_overflow = out_ovf_q;
  assign out_illegal  = out_ill_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural external ALU.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_control;
  logic [31:0] alu_result;
  logic        alu_overflow;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_overflow;
  logic        out_illegal;
  logic        force_ovf;

  int tests = 0;
  int fails = 0;

  alu_sequencer #(.N(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero),
    .out_overflow(out_overflow), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  // External ALU; force_ovf raises overflow on any op to probe masking.
  logic add_ovf, sub_ovf;
  always_comb begin
    alu_result = 32'h0;
    case (alu_control)
      4'b1000: alu_result = alu_a + alu_b;
      4'b1100: alu_result = alu_a - alu_b;
      4'b0101: alu_result = alu_a << alu_b[4:0];
      4'b1101: alu_result = {31'h0, $signed(alu_a) < $signed(alu_b)};
      4'b1111: alu_result = {31'h0, alu_a < alu_b};
      4'b0011: alu_result = alu_a ^ alu_b;
      4'b0110: alu_result = alu_a >> alu_b[4:0];
      4'b0111: alu_result = 32'($signed(alu_a) >>> alu_b[4:0]);
      4'b0010: alu_result = alu_a | alu_b;
      4'b0001: alu_result = alu_a & alu_b;
      default: alu_result = 32'h0;
    endcase
    add_ovf = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
    sub_ovf = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
    alu_overflow = force_ovf
                 | ((alu_control == 4'b1000) & add_ovf)
                 | ((alu_control == 4'b1100) & sub_ovf);
    alu_zero = (alu_result == 32'h0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one instruction from IDLE and walk it to completion.
  task automatic run_op(input string tag, input logic [31:0] ins,
                        input logic [31:0] r1, input logic [31:0] r2,
                        input logic legal, input logic [3:0] ectl,
                        input logic [31:0] eb, input logic [31:0] eres,
                        input logic ez, input logic eo, input logic eill);
    check({tag, ".in_ready_idle"}, 32'(in_ready), 32'h1);
    in_valid = 1'b1; instr = ins; rs1_val = r1; rs2_val = r2;
    @(posedge clk); #1;
    if (legal) begin
      // A second request during EXEC must be ignored.
      instr = 32'h0000_0063; rs1_val = 32'hDEAD_BEEF; rs2_val = 32'h1234_5678;
      check({tag, ".exec_ctrl"}, 32'(alu_control), 32'(ectl));
      check({tag, ".exec_a"}, alu_a, r1);
      check({tag, ".exec_b"}, alu_b, eb);
      check({tag, ".exec_valid"}, 32'(out_valid), 32'h0);
      check({tag, ".exec_ready"}, 32'(in_ready), 32'h0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check({tag, ".valid"}, 32'(out_valid), 32'h1);
    check({tag, ".ctrl_off"}, 32'(alu_control), 32'h0);
    check({tag, ".a_off"}, alu_a, 32'h0);
    check({tag, ".b_off"}, alu_b, 32'h0);
    check({tag, ".result"}, out_result, eres);
    check({tag, ".zero"}, 32'(out_zero), 32'(ez));
    check({tag, ".ovf"}, 32'(out_overflow), 32'(eo));
    check({tag, ".illegal"}, 32'(out_illegal), 32'(eill));
    check({tag, ".ready_resp"}, 32'(in_ready), 32'h0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".done_valid"}, 32'(out_valid), 32'h0);
    check({tag, ".done_ready"}, 32'(in_ready), 32'h1);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; force_ovf = 1'b0;
    instr = 32'h0; rs1_val = 32'h0; rs2_val = 32'h0;
    #12;
    check("rst.out_valid", 32'(out_valid), 32'h0);
    check("rst.alu_ctrl", 32'(alu_control), 32'h0);
    check("rst.alu_a", alu_a, 32'h0);
    check("rst.out_result", out_result, 32'h0);
    check("rst.flags", {29'h0, out_zero, out_overflow, out_illegal}, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst.in_ready", 32'(in_ready), 32'h1);

    // out_ready with no response pending is ignored.
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle.ready_ign", 32'(out_valid), 32'h0);

    run_op("add",  32'h0020_81B3, 32'd5, 32'd7, 1'b1, 4'b1000, 32'd7, 32'd12, 1'b0, 1'b0, 1'b0);
    run_op("srai", 32'h4040_D193, 32'h8000_0000, 32'h0, 1'b1, 4'b0111, 32'd4, 32'hF800_0000, 1'b0, 1'b0, 1'b0);
    run_op("addi", 32'hFFF0_8193, 32'd1, 32'h0, 1'b1, 4'b1000, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 1'b0);
    run_op("beq",  32'h0020_8063, 32'd3, 32'd3, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
`ifdef ALU_SEQ_OVERFLOW_TRAP_EN
    run_op("sub_ovf", 32'h4020_81B3, 32'h8000_0000, 32'd1, 1'b1, 4'b1100, 32'd1, 32'h0, 1'b1, 1'b1, 1'b1);
`else
    run_op("sub_ovf", 32'h4020_81B3, 32'h8000_0000, 32'd1, 1'b1, 4'b1100, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
`endif
    run_op("sll_f7bad", 32'h4020_91B3, 32'd1, 32'd1, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    run_op("slli_bad",  32'h4040_9193, 32'd1, 32'd0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    force_ovf = 1'b1;
    run_op("slt_ovfmask", 32'h0020_A1B3, 32'hFFFF_FFFF, 32'd1, 1'b1, 4'b1101, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
    force_ovf = 1'b0;
    run_op("sltu", 32'h0020_B1B3, 32'hFFFF_FFFF, 32'd1, 1'b1, 4'b1111, 32'd1, 32'd0, 1'b1, 1'b0, 1'b0);
    run_op("slli", 32'h0030_9193, 32'h0000_0003, 32'h0, 1'b1, 4'b0101, 32'd3, 32'h0000_0018, 1'b0, 1'b0, 1'b0);
    run_op("ori",  32'h0F00_E193, 32'h0000_000F, 32'h0, 1'b1, 4'b0010, 32'h0000_00F0, 32'h0000_00FF, 1'b0, 1'b0, 1'b0);

    // XOR held in RESP for 5 cycles, then reset mid-response.
    in_valid = 1'b1; instr = 32'h0020_C1B3; rs1_val = 32'hF0F0_F0F0; rs2_val = 32'hFF00_FF00;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("xor.exec_ctrl", 32'(alu_control), 32'h3);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check("hold.valid", 32'(out_valid), 32'h1);
      check("hold.result", out_result, 32'h0FF0_0FF0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    #1;
    check("rst_resp.valid", 32'(out_valid), 32'h0);
    check("rst_resp.result", out_result, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_resp.in_ready", 32'(in_ready), 32'h1);

    // Reset during EXEC discards the instruction.
    in_valid = 1'b1; instr = 32'h0020_81B3; rs1_val = 32'd1; rs2_val = 32'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rst_exec.ctrl_pre", 32'(alu_control), 32'h8);
    rst = 1'b0;
    #1;
    check("rst_exec.ctrl", 32'(alu_control), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_exec.no_resp", 32'(out_valid), 32'h0);
    end
    check("rst_exec.in_ready", 32'(in_ready), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
